pb_debounce: RTL and testbench
==============================

// Module: pb_debounce
// PURPOSE
//  Two-channel pushbutton conditioner between board pins and the game's pb_latch.
//  Synchronises raw pbl/pbr and debounces each channel with a saturating stability counter.
//  Drives clean levels plus one-cycle press pulses, and flags simultaneous presses for tie handling.
//  A channel stays disarmed after reset until its button is seen stably released.
// PARAMETERS
//  STABLE_CNT  1000  consecutive synced samples required to accept a level change (>=2)
//  CNT_W       10    counter width; must satisfy 2**CNT_W > STABLE_CNT
// PORTS
//  clk         in   1  system clock
//  rst         in   1  synchronous reset, active-low (rst==0 at posedge resets)
//  pbl_raw     in   1  left pushbutton pin, asynchronous, 1=pressed
//  pbr_raw     in   1  right pushbutton pin, asynchronous, 1=pressed
//  pbl         out  1  debounced left level
//  pbr         out  1  debounced right level
//  pbl_pulse   out  1  one-cycle strobe on accepted left press
//  pbr_pulse   out  1  one-cycle strobe on accepted right press
//  both_pulse  out  1  pbl_pulse & pbr_pulse in the same cycle
// BEHAVIOUR
//  Reset (rst==0 at posedge): sync flops=0, cnt=0, state=WAIT_REL; all outputs 0.
//  Sync: raw -> s1 -> s2 (two flops per channel); FSM sees only s2.
//  Per-channel FSM, independent, identical:
//   WAIT_REL : level 0, no pulses. s2==0 -> cnt++; s2==1 -> cnt=0.
//              cnt==STABLE_CNT-1 with s2==0 -> IDLE, cnt=0.
//   IDLE     : level 0. s2==1 -> PRESS_CHK, cnt=1.
//   PRESS_CHK: s2==1 -> cnt++; s2==0 -> IDLE, cnt=0 (bounce rejected).
//              cnt==STABLE_CNT-1 with s2==1 -> HELD, level=1, pulse=1 for this cycle only.
//   HELD     : level 1, pulse 0. s2==0 -> REL_CHK, cnt=1.
//   REL_CHK  : level stays 1. s2==0 -> cnt++; s2==1 -> HELD, cnt=0.
//              cnt==STABLE_CNT-1 with s2==0 -> IDLE, level=0. No pulse on release.
//  Latency: level/pulse rise exactly STABLE_CNT+2 posedges after raw goes steadily high.
//   Release latency is identical.
//  Counter never exceeds STABLE_CNT-1; no wrap is possible.
//  Outputs are registered; pulse is asserted in the same cycle level rises.
//  both_pulse is registered alongside the pulses and is high only if both accept on the same edge.
//   A one-cycle skew gives two separate pulses and no both_pulse.
//  Button held through reset: channel sits in WAIT_REL, produces no pulse until release+repress.
//  Reset mid-count or mid-HELD: immediate return to reset values; no pulse.
//   Pending count is discarded.
//  Single-cycle glitch on raw is either filtered by the sync flops or restarts the count;
//   it never produces a pulse.
// TESTING (bench uses STABLE_CNT=4, CNT_W=3)
//  1 Reset with pbl_raw=0, then raw steady 1 from cycle 10 -> pbl=1, pbl_pulse=1 at cycle 16 only.
//    pbr stays 0.
//  2 pbl_raw toggles 1,0,1,0,1 per cycle, then steady 1 -> exactly one pbl_pulse.
//    It occurs 6 cycles after the last rising edge.
//  3 Hold pbr_raw=1 through reset release -> no pulse while held.
//    Release 6+ cycles, press again -> one pulse.
//  4 Both raws rise on the same cycle -> pbl_pulse, pbr_pulse, both_pulse all 1 for one cycle.
//    Skew of 1 cycle -> both_pulse stays 0.
//  5 Pressed (pbl=1), raw drops for 2 cycles, then returns high -> pbl stays 1, no new pulse.
//    Steady release -> pbl=0 after 6 cycles.
//  6 Assert rst=0 while in PRESS_CHK (cnt=2) -> next edge: all outputs 0, state WAIT_REL.

Source files
------------

// File: rtl/pb_debounce.sv
// Two-channel pushbutton conditioner: synchronises and debounces the left/right
// buttons, producing clean levels, one-cycle press strobes and a tie flag.
// Each channel stays disarmed after reset until its button has been seen stably released.
module pb_debounce #(
    parameter int unsigned STABLE_CNT = 1000,
    parameter int unsigned CNT_W      = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic pbl_raw,
    input  logic pbr_raw,
    output logic pbl,
    output logic pbr,
    output logic pbl_pulse,
    output logic pbr_pulse,
    output logic both_pulse
);

    localparam int unsigned N_CH = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    typedef enum logic [2:0] {
        WAIT_REL,
        IDLE,
        PRESS_CHK,
        HELD,
        REL_CHK
    } state_t;

    logic [N_CH-1:0] raw_c;

    assign raw_c = {pbr_raw, pbl_raw};

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic             s1;
        logic             s2;
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             level;
        logic             pulse;
        logic             accept_c;

        // A press is accepted on the edge that delivers the last required stable high sample
        assign accept_c = (state == PRESS_CHK) && s2 && (cnt == CNT_LAST);

        // Two-flop synchroniser feeding the per-channel debounce FSM
        always_ff @(posedge clk) begin
            if (!rst) begin
                s1    <= 1'b0;
                s2    <= 1'b0;
                state <= WAIT_REL;
                cnt   <= '0;
                level <= 1'b0;
                pulse <= 1'b0;
            end else begin
                s1    <= raw_c[i];
                s2    <= s1;
                pulse <= accept_c;
                case (state)
                    WAIT_REL: begin
                        level <= 1'b0;
                        if (s2) begin
                            cnt <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    IDLE: begin
                        level <= 1'b0;
                        if (s2) begin
                            state <= PRESS_CHK;
                            cnt   <= CNT_W'(1);
                        end
                    end
                    PRESS_CHK: begin
                        if (!s2) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state <= HELD;
                            level <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    HELD: begin
                        level <= 1'b1;
                        if (!s2) begin
                            state <= REL_CHK;
                            cnt   <= CNT_W'(1);
                        end
                    end
                    REL_CHK: begin
                        if (s2) begin
                            state <= HELD;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state <= IDLE;
                            level <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= WAIT_REL;
                        level <= 1'b0;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // Tie flag registered alongside the per-channel press strobes
    always_ff @(posedge clk) begin
        if (!rst) begin
            both_pulse <= 1'b0;
        end else begin
            both_pulse <= g_ch[0].accept_c & g_ch[1].accept_c;
        end
    end

    assign pbl       = g_ch[0].level;
    assign pbr       = g_ch[1].level;
    assign pbl_pulse = g_ch[0].pulse;
    assign pbr_pulse = g_ch[1].pulse;

endmodule

// File: tb/tb_pb_debounce.sv
// Bench for pb_debounce: a sample-stream model checked every cycle, plus directed
// scenarios with hand-computed timing.
module tb_pb_debounce;

    localparam int STABLE = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pbl_raw = 1'b0;
    logic pbr_raw = 1'b0;
    logic pbl, pbr, pbl_pulse, pbr_pulse, both_pulse;

    int n_checks = 0;
    int n_pass   = 0;

    pb_debounce #(.STABLE_CNT(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .pbl_raw    (pbl_raw),
        .pbr_raw    (pbr_raw),
        .pbl        (pbl),
        .pbr        (pbr),
        .pbl_pulse  (pbl_pulse),
        .pbr_pulse  (pbr_pulse),
        .both_pulse (both_pulse)
    );

    always #5 clk = ~clk;

    // Channel model: raw delayed two edges, then a run length of samples that
    // disagree with the current level (or of lows while not yet armed).
    typedef struct {
        bit d1;
        bit d2;
        bit armed;
        bit lvl;
        bit pls;
        int run;
    } ch_t;

    ch_t m [2];
    bit  model_on = 1'b0;

    function automatic ch_t ch_step(input ch_t c, input bit raw, input bit r);
        ch_t n;
        bit  samp;
        n     = c;
        n.pls = 1'b0;
        if (!r) begin
            n.d1 = 1'b0; n.d2 = 1'b0; n.armed = 1'b0; n.lvl = 1'b0; n.run = 0;
            return n;
        end
        samp = c.d2;
        n.d2 = c.d1;
        n.d1 = raw;
        if (!c.armed) begin
            n.run = samp ? 0 : c.run + 1;
            if (n.run == STABLE) begin
                n.armed = 1'b1;
                n.run   = 0;
            end
        end else begin
            n.run = (samp != c.lvl) ? c.run + 1 : 0;
            if (n.run == STABLE) begin
                n.lvl = samp;
                n.pls = samp;
                n.run = 0;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m[0] <= ch_step(m[0], pbl_raw, rst);
        m[1] <= ch_step(m[1], pbr_raw, rst);
        if (!rst) model_on <= 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (model_on) begin
            chk("model_pbl",        32'(pbl),        32'(m[0].lvl));
            chk("model_pbr",        32'(pbr),        32'(m[1].lvl));
            chk("model_pbl_pulse",  32'(pbl_pulse),  32'(m[0].pls));
            chk("model_pbr_pulse",  32'(pbr_pulse),  32'(m[1].pls));
            chk("model_both_pulse", 32'(both_pulse), 32'(m[0].pls & m[1].pls));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic l, input logic r);
        pbl_raw = l;
        pbr_raw = r;
        rst     = 1'b0;
        @(negedge clk);
        chk("rst_pbl",        32'(pbl),        0);
        chk("rst_pbr",        32'(pbr),        0);
        chk("rst_pbl_pulse",  32'(pbl_pulse),  0);
        chk("rst_pbr_pulse",  32'(pbr_pulse),  0);
        chk("rst_both_pulse", 32'(both_pulse), 0);
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish at %0t", $time);
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int cnt_l, cnt_r, cnt_b, pos_l, pos_r, low_cnt;

        // Clean press: level and strobe six edges after raw rises
        do_reset(1'b0, 1'b0);
        cyc(10);
        pbl_raw = 1'b1;
        cyc(5);
        chk("t1_pre_pbl",       32'(pbl),       0);
        chk("t1_pre_pulse",     32'(pbl_pulse), 0);
        cyc(1);
        chk("t1_pbl",           32'(pbl),       1);
        chk("t1_pulse",         32'(pbl_pulse), 1);
        chk("t1_pbr",           32'(pbr),       0);
        chk("t1_model_pulse",   32'(m[0].pls),  1);
        cyc(1);
        chk("t1_pulse_gone",    32'(pbl_pulse), 0);
        chk("t1_pbl_hold",      32'(pbl),       1);

        // Bouncing press: one strobe, six edges after the last rising edge
        do_reset(1'b0, 1'b0);
        cyc(6);
        pbl_raw = 1'b1; cyc(1);
        pbl_raw = 1'b0; cyc(1);
        pbl_raw = 1'b1; cyc(1);
        pbl_raw = 1'b0; cyc(1);
        pbl_raw = 1'b1;
        cnt_l = 0; pos_l = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            if (pbl_pulse) begin cnt_l++; pos_l = k; end
        end
        chk("t2_pulse_count", 32'(cnt_l), 1);
        chk("t2_pulse_pos",   32'(pos_l), 6);

        // Held through reset: no strobe until released and pressed again
        do_reset(1'b0, 1'b1);
        cnt_r = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            cnt_r += int'(pbr_pulse);
        end
        chk("t3_held_pulses", 32'(cnt_r), 0);
        chk("t3_held_pbr",    32'(pbr),   0);
        pbr_raw = 1'b0;
        cyc(8);
        pbr_raw = 1'b1;
        cnt_r = 0; pos_r = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            if (pbr_pulse) begin cnt_r++; pos_r = k; end
        end
        chk("t3_repress_count", 32'(cnt_r), 1);
        chk("t3_repress_pos",   32'(pos_r), 6);

        // Simultaneous press flags a tie; a one-cycle skew does not
        do_reset(1'b0, 1'b0);
        cyc(6);
        pbl_raw = 1'b1;
        pbr_raw = 1'b1;
        cyc(5);
        chk("t4_pre_both", 32'(both_pulse), 0);
        cyc(1);
        chk("t4_pbl_pulse", 32'(pbl_pulse),  1);
        chk("t4_pbr_pulse", 32'(pbr_pulse),  1);
        chk("t4_both",      32'(both_pulse), 1);
        cyc(1);
        chk("t4_both_gone", 32'(both_pulse), 0);
        pbl_raw = 1'b0;
        pbr_raw = 1'b0;
        cyc(10);
        chk("t4_released_pbl", 32'(pbl), 0);
        pbl_raw = 1'b1;
        cyc(1);
        pbr_raw = 1'b1;
        cnt_b = 0; pos_l = 0; pos_r = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            cnt_b += int'(both_pulse);
            if (pbl_pulse) pos_l = k;
            if (pbr_pulse) pos_r = k;
        end
        chk("t4_skew_both",  32'(cnt_b), 0);
        chk("t4_skew_pos_l", 32'(pos_l), 5);
        chk("t4_skew_pos_r", 32'(pos_r), 6);

        // Short release dip is rejected; steady release drops the level after six edges
        do_reset(1'b0, 1'b0);
        cyc(6);
        pbl_raw = 1'b1;
        cyc(8);
        chk("t5_pressed", 32'(pbl), 1);
        pbl_raw = 1'b0;
        cyc(2);
        pbl_raw = 1'b1;
        cnt_l = 0; low_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            cyc(1);
            cnt_l   += int'(pbl_pulse);
            low_cnt += int'(!pbl);
        end
        chk("t5_dip_pulses", 32'(cnt_l),   0);
        chk("t5_dip_low",    32'(low_cnt), 0);
        pbl_raw = 1'b0;
        cyc(5);
        chk("t5_rel_pre", 32'(pbl), 1);
        cyc(1);
        chk("t5_rel_pbl",   32'(pbl),       0);
        chk("t5_rel_pulse", 32'(pbl_pulse), 0);

        // Reset mid-count discards the pending press and disarms the channel
        do_reset(1'b0, 1'b0);
        cyc(6);
        pbl_raw = 1'b1;
        cyc(4);
        chk("t6_counting_pbl", 32'(pbl), 0);
        rst = 1'b0;
        cyc(1);
        chk("t6_pbl",        32'(pbl),        0);
        chk("t6_pbl_pulse",  32'(pbl_pulse),  0);
        chk("t6_pbr",        32'(pbr),        0);
        chk("t6_pbr_pulse",  32'(pbr_pulse),  0);
        chk("t6_both_pulse", 32'(both_pulse), 0);
        rst = 1'b1;
        cnt_l = 0;
        for (int k = 0; k < 12; k++) begin
            cyc(1);
            cnt_l += int'(pbl_pulse) + int'(pbl);
        end
        chk("t6_disarmed", 32'(cnt_l), 0);
        pbl_raw = 1'b0;
        cyc(8);
        pbl_raw = 1'b1;
        cyc(6);
        chk("t6_recover_pulse", 32'(pbl_pulse), 1);
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
